// File: rtl/dbus_arbiter.sv
`default_nettype none
// ==========================================================================
// Module  : dbus_arbiter
// Desc    : Shares the data-memory port between CPU (default priority) and a
//           DMA master with starvation guard and locked bursts.
//           Optional perf counters enabled by DBUS_ARB_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ==========================================================================
module dbus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_byteen,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic        arb_owner
`ifdef DBUS_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_cpu_stall,
  output logic [31:0] perf_dma_stall,
  output logic [31:0] perf_forced
`endif
);

  localparam logic [0:0]       c_st_arb     = 1'b0;
  localparam logic [0:0]       c_st_dma_own = 1'b1;
  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] c_max_burst  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             resp_valid_q, resp_owner_q;
  logic             w_forced;
  logic [CNT_W-1:0] w_beat_next;

  // No access is issued while reset is held, so a burst cannot leak a beat.
  always_comb begin
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    w_forced = 1'b0;
    if (!reset) begin
      if (state_q == c_st_dma_own) begin
        d_gnt = d_req;
      end else if (d_req && (wait_cnt_q == c_starve_lim)) begin
        d_gnt    = 1'b1;
        w_forced = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else begin
        d_gnt = d_req;
      end
    end
  end

  assign w_beat_next = beat_cnt_q + c_cnt_one;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == c_st_arb) begin
      if (d_gnt || !d_req) begin
        wait_cnt_d = '0;
      end else if (wait_cnt_q < c_starve_lim) begin
        wait_cnt_d = wait_cnt_q + c_cnt_one;
      end
      if (d_gnt && d_lock && (MAX_BURST > 1)) begin
        state_d    = c_st_dma_own;
        beat_cnt_d = c_cnt_one;
      end
    end else if (!d_req) begin
      state_d    = c_st_arb;
      beat_cnt_d = '0;
    end else begin
      beat_cnt_d = w_beat_next;
      if (!d_lock || (w_beat_next == c_max_burst)) begin
        state_d    = c_st_arb;
        beat_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= c_st_arb;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      resp_valid_q <= c_gnt | d_gnt;
      resp_owner_q <= d_gnt;
    end
  end

  always_comb begin
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = '0;
    if (c_gnt) begin
      m_data_addr   = c_addr;
      m_data_wdata  = c_wdata;
      m_data_byteen = c_byteen;
    end else if (d_gnt) begin
      m_data_addr   = d_addr;
      m_data_wdata  = d_wdata;
      m_data_byteen = d_byteen;
    end
  end

  assign c_rvalid  = resp_valid_q & ~resp_owner_q;
  assign d_rvalid  = resp_valid_q & resp_owner_q;
  assign c_rdata   = c_rvalid ? m_data_rdata : '0;
  assign d_rdata   = d_rvalid ? m_data_rdata : '0;
  assign arb_owner = state_q[0];

`ifdef DBUS_ARB_PERF_CNT_EN
  logic [31:0] perf_cpu_stall_q, perf_dma_stall_q, perf_forced_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cpu_stall_q <= '0;
      perf_dma_stall_q <= '0;
      perf_forced_q    <= '0;
    end else begin
      if (c_req && !c_gnt) perf_cpu_stall_q <= perf_cpu_stall_q + 32'd1;
      if (d_req && !d_gnt) perf_dma_stall_q <= perf_dma_stall_q + 32'd1;
      if (w_forced)        perf_forced_q    <= perf_forced_q + 32'd1;
    end
  end

  assign perf_cpu_stall = perf_cpu_stall_q;
  assign perf_dma_stall = perf_dma_stall_q;
  assign perf_forced    = perf_forced_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// ==========================================================================
// Module  : tb_dbus_arbiter
// Desc    : Vector table, directed corner cases and randomized traffic for
//           dbus_arbiter against a cycle-level behavioural model.
// Rev     : 1.0  initial release
// ==========================================================================
module tb_dbus_arbiter;

  localparam int STARVE = 4;
  localparam int MAXB   = 8;

  logic        clk;
  logic        reset;
  logic        c_req, d_req, d_lock;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_byteen, d_byteen;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, arb_owner;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
`ifdef DBUS_ARB_PERF_CNT_EN
  logic [31:0] perf_cpu_stall, perf_dma_stall, perf_forced;
`endif

  dbus_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteen(d_byteen), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_rdata(m_data_rdata),
    .arb_owner(arb_owner)
`ifdef DBUS_ARB_PERF_CNT_EN
    , .perf_cpu_stall(perf_cpu_stall), .perf_dma_stall(perf_dma_stall),
    .perf_forced(perf_forced)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    c_addr = '0; c_wdata = '0; c_byteen = '0;
    d_addr = '0; d_wdata = '0; d_byteen = '0; m_data_rdata = '0;
    tick();
    reset = 1'b0;
  endtask

  // Fields, MSB first: rst, c_req, d_req, d_lock, exp c_gnt, exp d_gnt, exp arb_owner
  typedef struct packed {
    logic rst, cr, dr, dl, eg_c, eg_d, e_own;
  } vec_t;
  vec_t vecs [14];

  // Reference model state
  bit m_locked, m_rv, m_rown, e_c, e_d;
  int m_beats, m_refused;
  logic [31:0] e_addr;
  logic [3:0]  e_be;

  initial begin
    vecs[0]  = 7'b1000_000;
    vecs[1]  = 7'b0000_000;
    vecs[2]  = 7'b0100_100;
    vecs[3]  = 7'b0010_010;
    vecs[4]  = 7'b0110_100;
    vecs[5]  = 7'b0110_100;
    vecs[6]  = 7'b0110_100;
    vecs[7]  = 7'b0110_100;
    vecs[8]  = 7'b0110_010;
    vecs[9]  = 7'b0110_100;
    vecs[10] = 7'b0011_010;
    vecs[11] = 7'b0111_011;
    vecs[12] = 7'b0100_001;
    vecs[13] = 7'b0100_100;

    do_reset();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst; c_req = vecs[i].cr; d_req = vecs[i].dr; d_lock = vecs[i].dl;
      c_addr = 32'h100 + 32'(i); d_addr = 32'h800 + 32'(i);
      #3;
      chk1($sformatf("vec%0d c_gnt", i), c_gnt, vecs[i].eg_c);
      chk1($sformatf("vec%0d d_gnt", i), d_gnt, vecs[i].eg_d);
      chk1($sformatf("vec%0d arb_owner", i), arb_owner, vecs[i].e_own);
      tick();
    end

    // Reset then idle: nothing issued, no responses
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk32("idle byteen", {28'd0, m_data_byteen}, 32'd0);
      chk1("idle owner", arb_owner, 1'b0);
      chk1("idle rvalid", c_rvalid | d_rvalid | c_gnt | d_gnt, 1'b0);
      tick();
    end

    // CPU write then its ack
    c_req = 1'b1; c_addr = 32'h0000_1004; c_byteen = 4'hF; c_wdata = 32'hDEADBEEF;
    #3;
    chk1("wr c_gnt", c_gnt, 1'b1);
    chk32("wr m_addr", m_data_addr, 32'h1004);
    chk32("wr m_wdata", m_data_wdata, 32'hDEADBEEF);
    chk32("wr m_byteen", {28'd0, m_data_byteen}, 32'hF);
    tick();
    c_req = 1'b0;
    #3;
    chk1("wr c_rvalid", c_rvalid, 1'b1);
    chk1("wr d_rvalid", d_rvalid, 1'b0);
    chk32("wr idle byteen", {28'd0, m_data_byteen}, 32'd0);
    chk32("wr idle addr", m_data_addr, 32'd0);
    tick();

`ifdef DBUS_ARB_PERF_CNT_EN
    do_reset();
    c_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk32("perf_forced", perf_forced, 32'd1);
    chk32("perf_dma_stall", perf_dma_stall, 32'd4);
    chk32("perf_cpu_stall", perf_cpu_stall, 32'd1);
    c_req = 1'b0; d_req = 1'b0;
`endif

    // Locked burst of 12 beats, CPU request raised at beat 2
    do_reset();
    d_req = 1'b1; d_lock = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      c_req = (cyc >= 2 && cyc <= 9);
      d_addr = 32'h4000 + 32'(cyc * 4);
      #3;
      if (cyc == 9) begin
        chk1("burst cpu slot c_gnt", c_gnt, 1'b1);
        chk1("burst cpu slot d_gnt", d_gnt, 1'b0);
        chk1("burst cpu slot owner", arb_owner, 1'b0);
      end else begin
        chk1($sformatf("burst cyc%0d d_gnt", cyc), d_gnt, 1'b1);
        chk1($sformatf("burst cyc%0d c_gnt", cyc), c_gnt, 1'b0);
        chk1($sformatf("burst cyc%0d owner", cyc), arb_owner, (cyc != 1 && cyc != 10));
      end
      if (cyc == 10) chk1("burst cpu ack", c_rvalid, 1'b1);
      tick();
    end
    d_req = 1'b0; d_lock = 1'b0;
    #3;
    chk1("burst end owner", arb_owner, 1'b1);
    tick();
    #3;
    chk1("burst exit owner", arb_owner, 1'b0);
    tick();

    // DMA read
    do_reset();
    d_req = 1'b1; d_addr = 32'h2000; d_byteen = 4'h0;
    #3;
    chk1("rd d_gnt", d_gnt, 1'b1);
    chk32("rd m_addr", m_data_addr, 32'h2000);
    chk32("rd m_byteen", {28'd0, m_data_byteen}, 32'd0);
    tick();
    d_req = 1'b0; m_data_rdata = 32'h12345678;
    #3;
    chk1("rd d_rvalid", d_rvalid, 1'b1);
    chk32("rd d_rdata", d_rdata, 32'h12345678);
    chk32("rd c_rdata", c_rdata, 32'd0);
    chk1("rd c_rvalid", c_rvalid, 1'b0);
    tick();
    m_data_rdata = '0;

    // Reset during beat 3 of a locked burst
    do_reset();
    d_req = 1'b1; d_lock = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    #3;
    chk1("rst-burst owner", arb_owner, 1'b0);
    chk1("rst-burst d_rvalid", d_rvalid, 1'b0);
    chk1("rst-burst c_rvalid", c_rvalid, 1'b0);
`ifdef DBUS_ARB_PERF_CNT_EN
    chk32("rst-burst perf_dma_stall", perf_dma_stall, 32'd0);
    chk32("rst-burst perf_forced", perf_forced, 32'd0);
`endif
    tick();
    c_req = 1'b1; d_req = 1'b1;
    #3;
    chk1("rst-burst c_gnt", c_gnt, 1'b1);
    chk1("rst-burst d_gnt", d_gnt, 1'b0);
    tick();
    c_req = 1'b0; d_req = 1'b0;

    // Randomized traffic against the model
    do_reset();
    m_locked = 0; m_rv = 0; m_rown = 0; m_beats = 0; m_refused = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!c_req && $urandom_range(0, 99) < 40) begin
        c_req = 1'b1; c_addr = $urandom(); c_wdata = $urandom(); c_byteen = 4'($urandom());
      end
      if (!d_req && $urandom_range(0, 99) < 40) begin
        d_req = 1'b1; d_lock = ($urandom_range(0, 1) == 1);
        d_addr = $urandom(); d_wdata = $urandom(); d_byteen = 4'($urandom());
      end
      m_data_rdata = $urandom();

      // DMA wins when it owns the bus, is starved, or the CPU is idle
      e_d = m_locked ? d_req : (d_req && (m_refused >= STARVE || !c_req));
      e_c = !m_locked && c_req && !e_d;
      e_addr = e_c ? c_addr : (e_d ? d_addr : 32'd0);
      e_be   = e_c ? c_byteen : (e_d ? d_byteen : 4'd0);
      #3;
      chk1("rnd c_gnt", c_gnt, e_c);
      chk1("rnd d_gnt", d_gnt, e_d);
      chk1("rnd arb_owner", arb_owner, m_locked);
      chk32("rnd m_addr", m_data_addr, e_addr);
      chk32("rnd m_byteen", {28'd0, m_data_byteen}, {28'd0, e_be});
      chk1("rnd c_rvalid", c_rvalid, m_rv && !m_rown);
      chk1("rnd d_rvalid", d_rvalid, m_rv && m_rown);
      chk32("rnd c_rdata", c_rdata, (m_rv && !m_rown) ? m_data_rdata : 32'd0);
      chk32("rnd d_rdata", d_rdata, (m_rv && m_rown) ? m_data_rdata : 32'd0);

      m_rv = e_c || e_d; m_rown = e_d;
      if (m_locked) begin
        if (!d_req) m_locked = 0;
        else begin
          m_beats++;
          if (!d_lock || m_beats >= MAXB) m_locked = 0;
        end
      end else begin
        if (d_req && !e_d) begin
          if (m_refused < STARVE) m_refused++;
        end else m_refused = 0;
        if (e_d && d_lock && MAXB > 1) begin
          m_locked = 1; m_beats = 1;
        end
      end
      tick();

      if (e_c) c_req = 1'b0;
      if (e_d) begin
        d_req = d_lock && ($urandom_range(0, 99) < 75);
        d_lock = ($urandom_range(0, 99) < 85);
        d_addr = $urandom(); d_wdata = $urandom(); d_byteen = 4'($urandom());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-memory port (m_data_addr/m_data_wdata/m_data_byteen/m_data_rdata) between the CPU M-stage and a second bus master (DMA engine).
- CPU has default priority. A wait counter guarantees the DMA gets a slot within a bounded number of cycles, and a locked-burst mode gives the DMA back-to-back beats.
- Sits between CPU and the bridge/DM. c_gnt low is used by the CPU as an additional pipeline stall.

Parameters:
STARVE_LIMIT, 4, consecutive cycles the DMA may be refused before it is forced a slot (1..15)
MAX_BURST, 8, maximum beats one locked DMA burst may hold the bus (1..15)
CNT_W, 4, width of wait and beat counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
c_req  in  1  CPU access request (held until granted)
c_addr  in  32  CPU byte address
c_wdata  in  32  CPU write data
c_byteen  in  4  CPU byte enables; 4'b0000 = read
c_gnt  out  1  CPU access issued this cycle
c_rvalid  out  1  CPU response valid (cycle after issue)
c_rdata  out  32  CPU read data
d_req  in  1  DMA access request
d_lock  in  1  DMA requests burst ownership
d_addr  in  32  DMA byte address
d_wdata  in  32  DMA write data
d_byteen  in  4  DMA byte enables; 0 = read
d_gnt  out  1  DMA access issued this cycle
d_rvalid  out  1  DMA response valid
d_rdata  out  32  DMA read data
m_data_addr  out  32  memory address
m_data_wdata  out  32  memory write data
m_data_byteen  out  4  memory byte enables
m_data_rdata  in  32  memory read data, valid one cycle after issue
arb_owner  out  1  0 = ARB state, 1 = DMA_OWN state

Behaviour:
- Clock and reset: one clock clk; reset is synchronous, active-high.
- Reset effects: state=ARB, wait_cnt=0, beat_cnt=0, resp_valid=0, resp_owner=0, perf counters=0. All outputs read 0 in the cycle after reset is sampled.
- Reset mid-burst: drops the lock immediately and suppresses any pending response.
- Grants are combinational from state, counters and requests; exactly zero or one grant per cycle.
- An issue occurs when c_gnt or d_gnt is 1. Mux drives that requester's addr/wdata/byteen onto m_data_*.
- With no issue, m_data_byteen=0 and m_data_addr/m_data_wdata=0 (no spurious write).
- Response pipeline: on each issue register resp_valid=1 and resp_owner. Next cycle the owner's rvalid=1 and its rdata=m_data_rdata. The other side's rvalid=0 and rdata=0.
- rvalid is asserted for writes too (ack); rdata is meaningful for reads only.
- State ARB:
  - d_req && wait_cnt==STARVE_LIMIT: d_gnt (forced slot, overrides c_req).
  - else c_req: c_gnt.
  - else d_req: d_gnt.
  - If d_gnt && d_lock && MAX_BURST>1: next state DMA_OWN, beat_cnt=1.
- State DMA_OWN:
  - c_gnt=0; d_gnt=d_req; beat_cnt increments on each d_gnt.
  - Return to ARB when d_req=0, or d_lock=0 on a granted beat, or beat_cnt reaches MAX_BURST on a grant.
  - The cycle after exit, CPU priority applies; a new lock cannot chain over a pending c_req.
- wait_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle d_req && !d_gnt.
  - Clears on d_gnt or when d_req=0.
  - Frozen in DMA_OWN.
- Simultaneous c_req and d_req in ARB with wait_cnt<STARVE_LIMIT: CPU wins.
- Requesters must hold req/addr/wdata/byteen stable until granted; the arbiter does not latch requests.
- Data path: widths are fixed at 32; no address decoding here.

Optional Feature:
- Macro: DBUS_ARB_PERF_CNT_EN.
- Defined: adds three 32-bit wrapping counters plus output ports perf_cpu_stall, perf_dma_stall, perf_forced.
  - perf_cpu_stall: cycles with c_req && !c_gnt.
  - perf_dma_stall: cycles with d_req && !d_gnt.
  - perf_forced: forced-slot grants.
  - All clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then idle: all outputs 0, m_data_byteen=0, arb_owner=0 for every cycle.
- CPU write c_addr=0x0000_1004, c_byteen=4'b1111, c_wdata=0xDEADBEEF → c_gnt=1 that cycle, m_data_addr=0x1004; next cycle c_rvalid=1, d_rvalid=0.
- c_req and d_req both held constantly (no lock), STARVE_LIMIT=4 → c_gnt for 4 cycles, d_gnt on cycle 5 (perf_forced=1), then the pattern repeats every 5 cycles.
- DMA lock burst, d_lock=1 for 12 beats, MAX_BURST=8, c_req raised at beat 2:
  - beats 1-8 granted to DMA, arb_owner=1;
  - next cycle c_gnt=1;
  - DMA resumes after the CPU request drops.
- DMA read from 0x2000 with memory returning 0x12345678 → d_gnt, then next cycle d_rvalid=1, d_rdata=0x12345678, c_rdata=0.
- Reset asserted during beat 3 of a locked burst → next cycle arb_owner=0, d_rvalid=0, counters 0; a following c_req is granted immediately.
